byte_serializer: RTL and testbench
==================================

Name: byte_serializer

Overview:
- Downstream of the multi-ROM byte multiplexer; consumes its 8-bit data stream and drives one serial output line.
- Frames each accepted byte as: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1).
- A one-entry holding buffer decouples the byte producer from the bit-rate timing, so the producer stalls only when both the holding buffer and the shifter are occupied.

Parameters:
- CLKS_PER_BIT, 4: sysclk cycles per serial bit; legal range 2..255.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- sysclk, input, 1: system clock; all state updates on its rising edge.
- reset, input, 1: asynchronous, active-high reset.
- enable, input, 1: run gate. Low aborts any frame and flushes the holding buffer.
- data_in, input, 8: byte from the multiplexer stage.
- data_valid, input, 1: data_in is valid this cycle.
- ready, output, 1: holding buffer is empty; a byte is accepted on any edge where data_valid && ready && enable.
- serial_out, output, 1: serial line; idles high.
- busy, output, 1: a frame is in progress (any state except IDLE).
- bytes_sent, output, 16: count of completed frames; wraps at 0xFFFF to 0.

Behaviour:
- Reset values (asynchronous assertion): serial_out=1, ready=1, busy=0, bytes_sent=0, state=IDLE, holding buffer empty, bit_cnt=0, baud_cnt=0.
- States:
  - IDLE: serial_out=1.
  - START: serial_out=0.
  - DATA: serial_out=shift[0].
  - STOP: serial_out=1.
- serial_out is registered and reflects the state of the current cycle.
- Accept: on an edge where data_valid && ready && enable, data_in is written to the holding buffer and ready drops to 0 on the next cycle.
- Load: in IDLE with the buffer full, the next edge copies the buffer into the shifter, empties the buffer (ready=1) and enters START.
  - Latency: accept edge to first start-bit cycle is 2 cycles.
- Bit timing:
  - baud_cnt counts 0..CLKS_PER_BIT-1 in START, DATA and STOP.
  - At terminal count, baud_cnt returns to 0 and the bit advances.
  - In DATA, each advance shifts the shifter right by 1 and increments bit_cnt; after bit 7, go to STOP.
  - In STOP, after STOP_BITS bit periods, increment bytes_sent.
  - If the buffer is full at that moment, load it and go directly to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- Frame length: (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles.
- Simultaneous accept and load on the same edge: only legal when the buffer is empty. Because ready=0 whenever the buffer is full, acceptance and unload never collide; a refill happens at the earliest on the edge after the load.
- data_valid with ready=0: the byte is ignored. The producer must hold it; there is no overflow flag.
- enable low: on the next edge, state=IDLE, serial_out=1, buffer emptied, baud_cnt and bit_cnt cleared. bytes_sent is kept; a partial frame is not counted. No byte is accepted while enable is low.
- Reset mid-frame: immediate return to reset values; the line goes high asynchronously.
- The shifter is 8 bits; bit_cnt is 3 bits; baud_cnt is 8 bits.

Decomposition:
- Shared package holds:
  - the state enum: IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3;
  - the constants IDLE_LEVEL=1'b1 and START_LEVEL=1'b0.
- One natural sub-module: bit_timer, holding baud_cnt with a terminal-count strobe, CLKS_PER_BIT parameter, and clear/run inputs.
- Holding buffer and FSM stay in byte_serializer.

Test Plan:
1. Single frame, CLKS_PER_BIT=4: send 0xA5 -> after 2 cycles serial_out shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit held 4 cycles. busy=1 for 40 cycles, then bytes_sent=1.
2. Back-to-back: present 0x00 then 0xFF with data_valid held continuously -> second start bit immediately follows the first stop bit, no idle cycle. ready is 0 from the second accept until the second load. bytes_sent=2 after 80 cycles.
3. Back-pressure: hold data_valid=1 with 0x3C while a frame is running and the buffer is full -> ready=0 and no new byte is accepted until the load edge. Exactly 3 frames are sent for 3 distinct bytes.
4. Abort: drop enable during bit 4 of 0x81 -> serial_out=1 on the next cycle, busy=0, ready=1, bytes_sent unchanged. After enable returns, a new byte 0x55 transmits correctly.
5. Async reset mid-stop-bit with STOP_BITS=2 -> outputs at reset values before the next sysclk edge. The following 0x0F frame is 44 cycles long.
6. Counter wrap: force bytes_sent to 0xFFFF, send one byte -> bytes_sent=0x0000.

Source files
------------

// File: rtl/byte_serializer_pkg.sv
// Shared definitions for the byte serializer: frame state encoding and line levels.
package byte_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;

  // Level the serial line carries while the framer sits in a given state.
  function automatic logic line_level(input logic [1:0] state, input logic data_bit);
    logic level;
    case (state)
      IDLE:    level = IDLE_LEVEL;
      START:   level = START_LEVEL;
      DATA:    level = data_bit;
      STOP:    level = IDLE_LEVEL;
      default: level = IDLE_LEVEL;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Byte stream handshake between the multiplexer stage (master) and the serializer (slave).
interface byte_serializer_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       ready;

  modport master (output data_in, output data_valid, input ready);
  modport slave  (input data_in, input data_valid, output ready);
endinterface

// File: rtl/byte_serializer_bit_timer.sv
// Bit-period timer: counts sysclk cycles within one serial bit and strobes at the last one.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic sysclk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam logic [7:0] LAST_COUNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] baud_cnt_r;

  // Free-run 0..CLKS_PER_BIT-1 while a frame is active, parked at zero otherwise.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      baud_cnt_r <= 8'd0;
    end else if (clear || !run) begin
      baud_cnt_r <= 8'd0;
    end else if (baud_cnt_r == LAST_COUNT) begin
      baud_cnt_r <= 8'd0;
    end else begin
      baud_cnt_r <= baud_cnt_r + 8'd1;
    end
  end

  assign tick = run && (baud_cnt_r == LAST_COUNT);

endmodule

// File: rtl/byte_serializer.sv
// Byte serializer: one-entry holding buffer feeding a start/8N/stop framer on a single line.
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int STOP_BITS    = 1
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             enable,
  byte_serializer_if.slave bus,
  output logic             serial_out,
  output logic             busy,
  output logic [15:0]      bytes_sent
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);

  logic [1:0]  state_r, state_s;
  logic [7:0]  shift_r, shift_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  hold_r, hold_s;
  logic        hold_empty_r, hold_empty_s;
  logic [15:0] bytes_sent_r, bytes_sent_s;
  logic        serial_r, busy_r;
  logic        tick_s, accept_s, load_s, stop_done_s;
  logic        timer_clear_s, timer_run_s;

  assign timer_clear_s = !enable;
  assign timer_run_s   = (state_r != S_IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .sysclk (sysclk),
    .reset  (reset),
    .clear  (timer_clear_s),
    .run    (timer_run_s),
    .tick   (tick_s)
  );

  // The buffer is only written while empty and only unloaded while full, so the two never collide.
  assign accept_s    = enable && bus.data_valid && hold_empty_r;
  assign stop_done_s = (state_r == S_STOP) && tick_s && (bit_cnt_r == STOP_LAST);
  assign load_s      = enable && !hold_empty_r && ((state_r == S_IDLE) || stop_done_s);

  // Holding buffer: capture on accept, release on load, flush when disabled.
  always_comb begin
    hold_s       = hold_r;
    hold_empty_s = hold_empty_r;
    if (!enable) begin
      hold_empty_s = 1'b1;
    end else if (accept_s) begin
      hold_s       = bus.data_in;
      hold_empty_s = 1'b0;
    end else if (load_s) begin
      hold_empty_s = 1'b1;
    end else begin
      hold_empty_s = hold_empty_r;
    end
  end

  // Framing FSM: next state, shifter, bit/stop counter and completed-frame count.
  always_comb begin
    state_s      = state_r;
    shift_s      = shift_r;
    bit_cnt_s    = bit_cnt_r;
    bytes_sent_s = bytes_sent_r;
    if (!enable) begin
      state_s   = S_IDLE;
      bit_cnt_s = 3'd0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (load_s) begin
            state_s = S_START;
            shift_s = hold_r;
          end else begin
            state_s = S_IDLE;
          end
        end
        S_START: begin
          if (tick_s) begin
            state_s = S_DATA;
          end else begin
            state_s = S_START;
          end
        end
        S_DATA: begin
          if (tick_s) begin
            shift_s = {1'b0, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_s   = S_STOP;
              bit_cnt_s = 3'd0;
            end else begin
              bit_cnt_s = bit_cnt_r + 3'd1;
            end
          end else begin
            shift_s = shift_r;
          end
        end
        S_STOP: begin
          if (stop_done_s) begin
            // Reuse bit_cnt as the stop-bit counter; a waiting byte starts with no idle gap.
            bytes_sent_s = bytes_sent_r + 16'd1;
            bit_cnt_s    = 3'd0;
            state_s      = load_s ? S_START : S_IDLE;
            shift_s      = load_s ? hold_r : shift_r;
          end else if (tick_s) begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end else begin
            bit_cnt_s = bit_cnt_r;
          end
        end
        default: begin
          state_s   = S_IDLE;
          bit_cnt_s = 3'd0;
        end
      endcase
    end
  end

  // State registers; line and busy are registered from the next state so they match the current cycle.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      shift_r      <= 8'd0;
      bit_cnt_r    <= 3'd0;
      hold_r       <= 8'd0;
      hold_empty_r <= 1'b1;
      bytes_sent_r <= 16'd0;
      serial_r     <= IDLE_LEVEL;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      bit_cnt_r    <= bit_cnt_s;
      hold_r       <= hold_s;
      hold_empty_r <= hold_empty_s;
      bytes_sent_r <= bytes_sent_s;
      serial_r     <= line_level(state_s, shift_s[0]);
      busy_r       <= (state_s != S_IDLE);
    end
  end

  assign bus.ready  = hold_empty_r;
  assign serial_out = serial_r;
  assign busy       = busy_r;
  assign bytes_sent = bytes_sent_r;

endmodule

// File: tb/tb_byte_serializer.sv
// Directed, table-driven bench for byte_serializer (unit 0: 1 stop bit, unit 1: 2 stop bits).
module tb_byte_serializer;

  localparam int CPB     = 4;
  localparam int FRAME_A = 10 * CPB;

  typedef struct {
    logic [7:0]  data;
    logic [9:0]  frame;   // bit i = i-th transmitted bit (start, d0..d7, stop)
    logic [15:0] count;   // bytes_sent after the frame
  } vec_t;

  logic             sysclk = 1'b0;
  logic             reset;
  logic [1:0]       en, dv, rdy, ser, bsy;
  logic [1:0][7:0]  din;
  logic [1:0][15:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;

  vec_t       vecs [4];
  logic [7:0] s_data [4];
  logic [9:0] s_frame [4];
  int         p_main;
  logic       e_main;

  always #5 sysclk = ~sysclk;

  byte_serializer_if bus_a ();
  byte_serializer_if bus_b ();

  assign bus_a.data_in    = din[0];
  assign bus_a.data_valid = dv[0];
  assign rdy[0]           = bus_a.ready;
  assign bus_b.data_in    = din[1];
  assign bus_b.data_valid = dv[1];
  assign rdy[1]           = bus_b.ready;

  byte_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .sysclk(sysclk), .reset(reset), .enable(en[0]), .bus(bus_a),
    .serial_out(ser[0]), .busy(bsy[0]), .bytes_sent(cnt[0])
  );

  byte_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .sysclk(sysclk), .reset(reset), .enable(en[1]), .bus(bus_b),
    .serial_out(ser[1]), .busy(bsy[1]), .bytes_sent(cnt[1])
  );

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
  endtask

  // Send one byte into an idle unit and check every cycle of the resulting frame.
  task automatic run_frame(input int u, input logic [7:0] data, input logic [9:0] frame,
                           input int nstop, input logic [15:0] exp_count);
    int   len;
    int   p;
    logic exp_bit;
    len = (9 + nstop) * CPB;
    @(negedge sysclk);
    chk1("ready_idle", rdy[u], 1'b1);
    din[u] = data;
    dv[u]  = 1'b1;
    @(posedge sysclk);
    #1 dv[u] = 1'b0;
    @(negedge sysclk);
    chk1("line_before_start", ser[u], 1'b1);
    chk1("ready_after_accept", rdy[u], 1'b0);
    for (int c = 0; c < len; c++) begin
      @(negedge sysclk);
      p = c / CPB;
      exp_bit = (p > 9) ? 1'b1 : frame[p];
      chk1("frame_bit", ser[u], exp_bit);
      chk1("busy_in_frame", bsy[u], 1'b1);
    end
    @(negedge sysclk);
    chk1("busy_after_frame", bsy[u], 1'b0);
    chk1("line_after_frame", ser[u], 1'b1);
    chk16("bytes_sent", cnt[u], exp_count);
  endtask

  // Hold data_valid continuously over n bytes (s_data/s_frame) and check the back-to-back stream.
  task automatic stream(input int u, input int n, input logic [15:0] base);
    int          idx;
    int          k;
    int          total;
    logic        acc;
    logic        e_ser, e_busy, e_rdy;
    logic [15:0] e_cnt;
    idx   = 0;
    total = n * FRAME_A;
    for (int c = 0; c < total + 4; c++) begin
      @(negedge sysclk);
      if (c == 0) begin
        din[u] = s_data[0];
        dv[u]  = 1'b1;
      end
      k = c - 2;
      if (k < 0 || k >= total) e_ser = 1'b1;
      else e_ser = s_frame[k / FRAME_A][(k % FRAME_A) / CPB];
      e_busy = (k >= 0) && (k < total);
      if (k < 0) e_cnt = base;
      else if (k >= total) e_cnt = base + 16'(n);
      else e_cnt = base + 16'(k / FRAME_A);
      if (c == 0) e_rdy = 1'b1;
      else if (c == 1) e_rdy = 1'b0;
      else if (k >= (n - 1) * FRAME_A) e_rdy = 1'b1;
      else e_rdy = ((k % FRAME_A) == 0);
      chk1("stream_line", ser[u], e_ser);
      chk1("stream_busy", bsy[u], e_busy);
      chk1("stream_ready", rdy[u], e_rdy);
      chk16("stream_count", cnt[u], e_cnt);
      acc = dv[u] & rdy[u];
      @(posedge sysclk);
      #1;
      if (acc) begin
        idx++;
        if (idx < n) din[u] = s_data[idx];
        else dv[u] = 1'b0;
      end
    end
  endtask

  initial begin
    vecs[0] = '{8'hA5, 10'b1_10100101_0, 16'd1};
    vecs[1] = '{8'h3C, 10'b1_00111100_0, 16'd2};
    vecs[2] = '{8'h81, 10'b1_10000001_0, 16'd3};
    vecs[3] = '{8'h55, 10'b1_01010101_0, 16'd4};

    reset = 1'b1;
    en    = 2'b11;
    dv    = 2'b00;
    din   = '0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk1("reset_line", ser[u], 1'b1);
      chk1("reset_ready", rdy[u], 1'b1);
      chk1("reset_busy", bsy[u], 1'b0);
      chk16("reset_count", cnt[u], 16'd0);
    end
    @(negedge sysclk);
    reset = 1'b0;

    // Single frames from the vector table.
    for (int i = 0; i < 4; i++) begin
      run_frame(0, vecs[i].data, vecs[i].frame, 1, vecs[i].count);
    end

    // Back-to-back 0x00 then 0xFF.
    s_data[0] = 8'h00; s_frame[0] = 10'b1_00000000_0;
    s_data[1] = 8'hFF; s_frame[1] = 10'b1_11111111_0;
    stream(0, 2, 16'd4);

    // Back-pressure: 0x3C held while the buffer is full.
    s_data[0] = 8'h11; s_frame[0] = 10'b1_00010001_0;
    s_data[1] = 8'h22; s_frame[1] = 10'b1_00100010_0;
    s_data[2] = 8'h3C; s_frame[2] = 10'b1_00111100_0;
    stream(0, 3, 16'd6);

    // Abort 0x81 during data bit 4.
    @(negedge sysclk);
    din[0] = 8'h81;
    dv[0]  = 1'b1;
    @(posedge sysclk);
    #1 dv[0] = 1'b0;
    @(posedge sysclk);
    repeat (22) @(negedge sysclk);
    chk1("abort_pre_line", ser[0], 1'b0);
    chk1("abort_pre_busy", bsy[0], 1'b1);
    en[0] = 1'b0;
    @(negedge sysclk);
    chk1("abort_line", ser[0], 1'b1);
    chk1("abort_busy", bsy[0], 1'b0);
    chk1("abort_ready", rdy[0], 1'b1);
    chk16("abort_count", cnt[0], 16'd9);
    din[0] = 8'h55;
    dv[0]  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge sysclk);
      chk1("disabled_ready", rdy[0], 1'b1);
      chk1("disabled_busy", bsy[0], 1'b0);
      chk1("disabled_line", ser[0], 1'b1);
    end
    dv[0] = 1'b0;
    en[0] = 1'b1;
    run_frame(0, 8'h55, 10'b1_01010101_0, 1, 16'd10);

    // Counter wrap from 0xFFFF.
    @(negedge sysclk);
    dut_a.bytes_sent_r = 16'hFFFF;
    @(negedge sysclk);
    chk16("wrap_preset", cnt[0], 16'hFFFF);
    run_frame(0, 8'hA5, 10'b1_10100101_0, 1, 16'h0000);

    // Two stop bits: asynchronous reset during the second stop bit.
    @(negedge sysclk);
    din[1] = 8'h0F;
    dv[1]  = 1'b1;
    @(posedge sysclk);
    #1 dv[1] = 1'b0;
    @(posedge sysclk);
    for (int c = 0; c < 42; c++) begin
      @(negedge sysclk);
      p_main = c / CPB;
      e_main = (p_main > 9) ? 1'b1 : vecs[0].frame[0];
      if (p_main <= 9) begin
        s_frame[0] = 10'b1_00001111_0;
        e_main = s_frame[0][p_main];
      end else begin
        e_main = 1'b1;
      end
      chk1("stop2_line", ser[1], e_main);
      chk1("stop2_busy", bsy[1], 1'b1);
    end
    #1 reset = 1'b1;
    #1;
    chk1("async_reset_line", ser[1], 1'b1);
    chk1("async_reset_busy", bsy[1], 1'b0);
    chk1("async_reset_ready", rdy[1], 1'b1);
    chk16("async_reset_count", cnt[1], 16'd0);
    #1 reset = 1'b0;
    run_frame(1, 8'h0F, 10'b1_00001111_0, 2, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
